seg_display_scan: RTL and testbench

Drives the board's 6-digit multiplexed common-anode 7-segment display from the time-of-day outputs of `clock`. Takes packed-BCD `hour`/`minute`/`second`, scans one digit per slot, and decodes it to segments. It also blinks the field being edited in set modes, and the whole display while `alert` is high. Sits directly downstream of `clock` and shares its clock and reset.

---
 rtl/seg_display_scan.sv | 124 ++++++++++++
 tb/tb_seg_display_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Six-digit multiplexed common-anode 7-segment scanner for packed-BCD time of day, with field/alert blink.
// Latency: an/seg/dp registered, one cycle after idx/blink/inputs; free-running, no backpressure.
module seg_display_scan #(
  parameter int SCAN_DIV  = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [1:0] mode,
  input  logic       turn,
  input  logic       alert,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_q, blink_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nibble;
  logic          set_mode;
  logic          in_field;
  logic          hide;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    slot_end  = (pcnt_q == PCNT_MAX);
    frame_end = slot_end && (idx_q == 3'd5);

    pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (slot_end) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_end) begin
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    case (idx_q)
      3'd0:    nibble = second[3:0];
      3'd1:    nibble = second[7:4];
      3'd2:    nibble = minute[3:0];
      3'd3:    nibble = minute[7:4];
      3'd4:    nibble = hour[3:0];
      default: nibble = hour[7:4];
    endcase

    // Mode 3 falls outside set_mode, so it behaves as run mode.
    set_mode = (mode == 2'd1) || (mode == 2'd2);
    in_field = turn ? (idx_q >= 3'd4) : ((idx_q == 3'd2) || (idx_q == 3'd3));
    hide     = blink_q && (alert || (set_mode && in_field));

    if (hide) begin
      an_d  = 6'h3F;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = decode(nibble);
      dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4) || ((idx_q == 3'd0) && (mode == 2'd2)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q  <= '0;
      idx_q   <= 3'd0;
      fcnt_q  <= '0;
      blink_q <= 1'b0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan with SCAN_DIV=4, BLINK_DIV=2.
module tb_seg_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] hour = 8'h00;
  logic [7:0] minute = 8'h00;
  logic [7:0] second = 8'h00;
  logic [1:0] mode = 2'd0;
  logic       turn = 1'b0;
  logic       alert = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seg_display_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second),
    .mode(mode), .turn(turn), .alert(alert), .an(an), .seg(seg), .dp(dp)
  );

  typedef struct {
    int         cyc;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  // Edges since reset release; edge 1 is the first output update.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc = 0;
    else cyc = cyc + 1;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;  4'd2: seg_of = 7'h24;
      4'd3: seg_of = 7'h30;  4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
      4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;  4'd8: seg_of = 7'h00;
      4'd9: seg_of = 7'h10;  default: seg_of = 7'h3F;
    endcase
  endfunction

  function automatic logic hide_phase(input int n);
    return (((n - 1) / 48) % 2) == 1;
  endfunction

  // Expected outputs after edge n: slot changes every 4 edges, blink every 48.
  function automatic exp_t model(input int n);
    exp_t m;
    int slot;
    logic [3:0] nib;
    logic hid;
    slot = ((n - 1) / 4) % 6;
    case (slot)
      0: nib = second[3:0];
      1: nib = second[7:4];
      2: nib = minute[3:0];
      3: nib = minute[7:4];
      4: nib = hour[3:0];
      default: nib = hour[7:4];
    endcase
    hid = hide_phase(n) && (alert || (((mode == 2'd1) || (mode == 2'd2)) &&
          (turn ? (slot >= 4) : ((slot == 2) || (slot == 3)))));
    m.cyc = n;
    if (hid) begin
      m.an = 6'h3F; m.seg = 7'h7F; m.dp = 1'b1;
    end else begin
      m.an  = ~(6'b000001 << slot);
      m.seg = seg_of(nib);
      m.dp  = !((slot == 2) || (slot == 4) || ((slot == 0) && (mode == 2'd2)));
    end
    return m;
  endfunction

  task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d: got %h, expected %h", name, n, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc >= 0 && e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_entry: expected edge %0d, now at edge %0d", e.cyc, cyc);
        end else begin
          check("an", e.cyc, 32'(an), 32'(e.an));
          check("seg", e.cyc, 32'(seg), 32'(e.seg));
          check("dp", e.cyc, 32'(dp), 32'(e.dp));
        end
      end
      if (done) begin
        if (q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL leftover_entries: got %0d unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic push_reset_state();
    exp_t m;
    m.cyc = -1; m.an = 6'h3F; m.seg = 7'h7F; m.dp = 1'b1;
    q.push_back(m);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      q.push_back(model(cyc + 1));
      @(negedge clk);
    end
  endtask

  initial begin : stim
    // Power-on reset: outputs blanked while reset is held.
    push_reset_state();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hour = 8'h12; minute = 8'h34; second = 8'h56;
    run(14);

    // Async reset mid-slot (idx=3); checked before any further clock edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    push_reset_state();
    @(negedge clk);
    reset = 1'b0;
    run(52);

    // Non-decimal nibbles show a dash.
    second = 8'h5A; minute = 8'hF0;
    run(24);
    second = 8'h56; minute = 8'h34;

    // Time-set, hour field then minute field.
    mode = 2'd1; turn = 1'b1;
    run(100);
    turn = 1'b0;
    run(100);

    // Alarm-set, minute field, slot-0 dp indicator.
    mode = 2'd2; turn = 1'b0;
    run(100);

    // Mode 3 behaves as run mode.
    mode = 2'd3; turn = 1'b1;
    run(60);

    // Alert blinks everything; drop it mid-hide.
    mode = 2'd0; alert = 1'b1;
    run(100);
    for (int i = 0; i < 100; i++) begin
      if (hide_phase(cyc + 1) && ((cyc % 48) >= 10)) break;
      run(1);
    end
    alert = 1'b0;
    run(12);

    done = 1'b1;
  end

endmodule
